// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a MIPS instruction into ALU control and operands
// and holds the result in a one-entry valid/ready output register.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        in_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic        in_ready,
    output logic        out_valid,
    output logic [3:0]  alu_control,
    output logic [31:0] operand_A,
    output logic [31:0] operand_B,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        illegal
);

    localparam logic [3:0] C_ADD  = 4'h0;
    localparam logic [3:0] C_SUB  = 4'h1;
    localparam logic [3:0] C_AND  = 4'h2;
    localparam logic [3:0] C_OR   = 4'h3;
    localparam logic [3:0] C_XOR  = 4'h4;
    localparam logic [3:0] C_NOR  = 4'h5;
    localparam logic [3:0] C_SLL  = 4'h6;
    localparam logic [3:0] C_SRL  = 4'h7;
    localparam logic [3:0] C_SRA  = 4'h8;
    localparam logic [3:0] C_SLT  = 4'h9;
    localparam logic [3:0] C_PASB = 4'hB;
    localparam logic [3:0] C_LINK = 4'hC;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [15:0] w_imm;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic        w_unused;

    assign w_op     = instr[31:26];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_shamt  = instr[10:6];
    assign w_funct  = instr[5:0];
    assign w_imm    = instr[15:0];
    assign w_sext   = {{16{w_imm[15]}}, w_imm};
    assign w_zext   = {16'h0000, w_imm};
    assign w_unused = ^instr[25:21];

    logic [3:0]  w_ctrl;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_dest;
    logic        w_rw;
    logic        w_ill;

    always_comb begin
        w_ctrl = C_ADD;
        w_a    = rs_data;
        w_b    = rt_data;
        w_dest = w_rt;
        w_rw   = 1'b1;
        w_ill  = 1'b0;
        case (w_op)
            6'h00: begin
                w_dest = w_rd;
                case (w_funct)
                    6'h20, 6'h21: w_ctrl = C_ADD;
                    6'h22, 6'h23: w_ctrl = C_SUB;
                    6'h24:        w_ctrl = C_AND;
                    6'h25:        w_ctrl = C_OR;
                    6'h26:        w_ctrl = C_XOR;
                    6'h27:        w_ctrl = C_NOR;
                    6'h2A, 6'h2B: w_ctrl = C_SLT;
                    6'h00: begin w_ctrl = C_SLL; w_a = {27'b0, w_shamt}; end
                    6'h02: begin w_ctrl = C_SRL; w_a = {27'b0, w_shamt}; end
                    6'h03: begin w_ctrl = C_SRA; w_a = {27'b0, w_shamt}; end
                    6'h04: begin w_ctrl = C_SLL; w_a = {27'b0, rs_data[4:0]}; end
                    6'h06: begin w_ctrl = C_SRL; w_a = {27'b0, rs_data[4:0]}; end
                    6'h07: begin w_ctrl = C_SRA; w_a = {27'b0, rs_data[4:0]}; end
                    6'h09: begin w_ctrl = C_LINK; w_b = pc; end
                    default: w_ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin w_ctrl = C_ADD; w_b = w_sext; end
            6'h0A, 6'h0B: begin w_ctrl = C_SLT; w_b = w_sext; end
            6'h0C: begin w_ctrl = C_AND; w_b = w_zext; end
            6'h0D: begin w_ctrl = C_OR;  w_b = w_zext; end
            6'h0E: begin w_ctrl = C_XOR; w_b = w_zext; end
            6'h0F: begin w_ctrl = C_PASB; w_b = {w_imm, 16'h0000}; end
            6'h23: begin w_ctrl = C_ADD; w_b = w_sext; end
            6'h2B: begin w_ctrl = C_ADD; w_b = w_sext; w_rw = 1'b0; end
            6'h04, 6'h05: begin w_ctrl = C_SUB; w_rw = 1'b0; end
            6'h03: begin w_ctrl = C_LINK; w_b = pc; w_dest = 5'd31; end
            default: w_ill = 1'b1;
        endcase
        // Illegal entries still issue, but with a fully zeroed payload
        if (w_ill) begin
            w_ctrl = C_ADD;
            w_a    = 32'h0;
            w_b    = 32'h0;
            w_dest = 5'd0;
            w_rw   = 1'b0;
        end
    end

    logic        r_valid;
    logic [3:0]  r_ctrl;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_dest;
    logic        r_rw;
    logic        r_ill;
    logic        w_in_ready;
    logic        w_load;

    assign w_in_ready = (!r_valid || out_ready) && !flush;
    assign w_load     = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= 4'h0;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_dest  <= 5'd0;
            r_rw    <= 1'b0;
            r_ill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_a     <= w_a;
            r_b     <= w_b;
            r_dest  <= w_dest;
            r_rw    <= w_rw;
            r_ill   <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_valid;
    assign alu_control = r_ctrl;
    assign operand_A   = r_a;
    assign operand_B   = r_b;
    assign dest_reg    = r_dest;
    assign reg_write   = r_rw;
    assign illegal     = r_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, handshake,
// backpressure, flush and asynchronous reset.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  alu_control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .pc          (pc),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .alu_control (alu_control),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .dest_reg    (dest_reg),
        .reg_write   (reg_write),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] d,
                           input logic rw, input logic ill);
        chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".ctrl"},  {28'b0, alu_control}, {28'b0, c});
        chk({tag, ".A"},     operand_A, a);
        chk({tag, ".B"},     operand_B, b);
        chk({tag, ".dest"},  {27'b0, dest_reg}, {27'b0, d});
        chk({tag, ".rw"},    {31'b0, reg_write}, {31'b0, rw});
        chk({tag, ".ill"},   {31'b0, illegal}, {31'b0, ill});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] p);
        instr   = i;
        rs_data = rs;
        rt_data = rt;
        pc      = p;
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = 32'h0;
        pc        = 32'h0;
        rs_data   = 32'h0;
        rt_data   = 32'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #3;
        chk_out("reset", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        chk("reset.in_ready", {31'b0, in_ready}, 32'h1);
        #20;
        rst_n = 1'b1;

        // first edge after reset captures
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(32'h00851020, 32'd7, 32'd9, 32'h100);
        step();
        chk_out("add", 1'b1, 4'h0, 32'd7, 32'd9, 5'd2, 1'b1, 1'b0);

        drive(32'h2023FFFF, 32'd5, 32'd0, 32'h104);
        step();
        chk_out("addi", 1'b1, 4'h0, 32'd5, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0);

        drive(32'h3423FFFF, 32'd5, 32'd0, 32'h108);
        step();
        chk_out("ori", 1'b1, 4'h3, 32'd5, 32'h0000FFFF, 5'd3, 1'b1, 1'b0);

        drive(32'h3C031234, 32'd5, 32'd0, 32'h10C);
        step();
        chk_out("lui", 1'b1, 4'hB, 32'd5, 32'h12340000, 5'd3, 1'b1, 1'b0);

        drive(32'h00051103, 32'h11, 32'h80000000, 32'h110);
        step();
        chk_out("sra", 1'b1, 4'h8, 32'd4, 32'h80000000, 5'd2, 1'b1, 1'b0);

        drive(32'h0C000100, 32'h22, 32'h33, 32'h400);
        step();
        chk_out("jal", 1'b1, 4'hC, 32'h22, 32'h400, 5'd31, 1'b1, 1'b0);

        drive(32'h00C51004, 32'h23, 32'h55, 32'h404);
        step();
        chk_out("sllv", 1'b1, 4'h6, 32'd3, 32'h55, 5'd2, 1'b1, 1'b0);

        drive(32'hAC230008, 32'h1000, 32'h77, 32'h408);
        step();
        chk_out("sw", 1'b1, 4'h0, 32'h1000, 32'd8, 5'd3, 1'b0, 1'b0);

        drive(32'h10230004, 32'h9, 32'hA, 32'h40C);
        step();
        chk_out("beq", 1'b1, 4'h1, 32'h9, 32'hA, 5'd3, 1'b0, 1'b0);

        drive(32'h00000001, 32'h9, 32'hA, 32'h410);
        step();
        chk_out("badfunct", 1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);

        // backpressure: held add must stay frozen while ori waits
        drive(32'h00851020, 32'd7, 32'd9, 32'h500);
        step();
        out_ready = 1'b0;
        drive(32'h3423FFFF, 32'd5, 32'd0, 32'h504);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp.in_ready", {31'b0, in_ready}, 32'h0);
            step();
            chk_out("bp.hold", 1'b1, 4'h0, 32'd7, 32'd9, 5'd2, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'b0, in_ready}, 32'h1);
        step();
        chk_out("bp.next", 1'b1, 4'h3, 32'd5, 32'h0000FFFF, 5'd3, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        chk("drain.valid", {31'b0, out_valid}, 32'h0);

        // flush while holding an entry and offered a new one
        in_valid = 1'b1;
        drive(32'h00851020, 32'd7, 32'd9, 32'h600);
        step();
        drive(32'h3C031234, 32'd1, 32'd2, 32'h604);
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        chk("flush.in_ready", {31'b0, in_ready}, 32'h0);
        step();
        chk("flush.valid", {31'b0, out_valid}, 32'h0);
        chk("flush.nocap", operand_B, 32'd9);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush.after", {31'b0, out_valid}, 32'h0);

        // asynchronous reset mid-stall
        in_valid = 1'b1;
        drive(32'h0C000100, 32'h22, 32'h33, 32'h700);
        step();
        in_valid = 1'b0;
        step();
        chk("stall.valid", {31'b0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("areset", 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #12;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // undefined opcode still issues
        in_valid = 1'b1;
        drive(32'hFC000000, 32'h5, 32'h6, 32'h800);
        step();
        chk_out("illegal", 1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        in_valid = 1'b0;
        step();
        chk("end.valid", {31'b0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
